mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit external memory bus.
// Optional MEM_BUS_ARBITER_LOCK_EN adds per-master bus lock for atomic RMW.
module mem_bus_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [15:0] m0_addr_i,
  input  logic [15:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [15:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] m1_rdata_o,
`ifdef MEM_BUS_ARBITER_LOCK_EN
  input  logic        m0_lock_i,
  input  logic        m1_lock_i,
`endif
  output logic [15:0] addr_o,
  output logic        re_o,
  output logic        we_o,
  output logic [15:0] data_o,
  output logic        data_oe_o,
  input  logic [15:0] data_i,
  input  logic        needWait_i,
  output logic [1:0]  grant_o
);

  localparam int CL = $clog2(MAX_WAIT + 1);
  localparam int CW = (CL > 4) ? CL : 4;
  localparam logic [CW-1:0] SAT =
    (MAX_WAIT == 0) ? {CW{1'b1}} : CW'(MAX_WAIT);
  localparam logic [CW-1:0] LAST = SAT - 1'b1;
  localparam bit TO_EN = (MAX_WAIT != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [15:0]   rdata0_q, rdata0_d;
  logic [15:0]   rdata1_q, rdata1_d;
  logic [1:0]    req;
  logic          gnt;
  logic          pick;
  logic          lock_held;
  logic          lock_id;

  assign req = {m1_req_i, m0_req_i};

`ifdef MEM_BUS_ARBITER_LOCK_EN
  logic       lock_act_q, lock_act_d;
  logic       lock_id_q, lock_id_d;
  logic [1:0] lock_in;

  assign lock_in   = {m1_lock_i, m0_lock_i};
  assign lock_held = lock_act_q & lock_in[lock_id_q];
  assign lock_id   = lock_id_q;

  // Release only in IDLE; record holder at completion
  always_comb begin
    lock_act_d = lock_act_q;
    lock_id_d  = lock_id_q;
    if (state_q == IDLE && lock_act_q &&
        !lock_in[lock_id_q]) begin
      lock_act_d = 1'b0;
    end
    if (state_q == DONE && lock_in[owner_q]) begin
      lock_act_d = 1'b1;
      lock_id_d  = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_act_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  assign lock_held = 1'b0;
  assign lock_id   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;
    pick     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lock_held) begin
          gnt  = req[lock_id];
          pick = lock_id;
        end else begin
          unique case (1'b1)
            (req == 2'b11): begin
              gnt  = 1'b1;
              pick = ~last_q;
            end
            (req == 2'b01): begin
              gnt  = 1'b1;
              pick = 1'b0;
            end
            (req == 2'b10): begin
              gnt  = 1'b1;
              pick = 1'b1;
            end
            default: begin
              gnt  = 1'b0;
              pick = 1'b0;
            end
          endcase
        end
        if (gnt) begin
          state_d = BUS;
          owner_d = pick;
          we_d    = pick ? m1_we_i : m0_we_i;
          addr_d  = pick ? m1_addr_i : m0_addr_i;
          wdata_d = pick ? m1_wdata_i : m0_wdata_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (!lock_held) last_d = pick;
        end
      end
      BUS: begin
        if (!needWait_i) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) rdata1_d = data_i;
            else         rdata0_d = data_i;
          end
        end else begin
          if (cnt_q != SAT) cnt_d = cnt_q + 1'b1;
          if (TO_EN && cnt_q == LAST) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  logic in_bus, in_done;
  assign in_bus  = (state_q == BUS);
  assign in_done = (state_q == DONE);

  assign addr_o     = addr_q;
  assign data_o     = wdata_q;
  assign re_o       = in_bus & ~we_q;
  assign we_o       = in_bus & we_q;
  assign data_oe_o  = in_bus & we_q;
  assign grant_o    = (state_q == IDLE) ? 2'b00 :
                      (owner_q ? 2'b10 : 2'b01);
  assign m0_ack_o   = in_done & ~owner_q;
  assign m1_ack_o   = in_done & owner_q;
  assign m0_err_o   = in_done & ~owner_q & err_q;
  assign m1_err_o   = in_done & owner_q & err_q;
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level model.
// Lock scenario runs when MEM_BUS_ARBITER_LOCK_EN is defined.
module tb_mem_bus_arbiter;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  wr = 2'b00;
  logic [1:0]  lock = 2'b00;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic        ack0, ack1, err0, err1;
  logic [15:0] rd0, rd1;
  logic [15:0] b_addr, b_do;
  logic        b_re, b_we, b_oe;
  logic [15:0] b_di = 16'h0;
  logic        b_wait = 1'b0;
  logic [1:0]  grant;

  int          total = 0;
  int          bad = 0;
  int          last = 1;
  logic [15:0] mrd [2];
  bit          lk_act = 0;
  int          lk_id = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m0_req_i(req[0]),
    .m0_we_i(wr[0]),
    .m0_addr_i(addr[0]),
    .m0_wdata_i(wdata[0]),
    .m0_ack_o(ack0),
    .m0_err_o(err0),
    .m0_rdata_o(rd0),
    .m1_req_i(req[1]),
    .m1_we_i(wr[1]),
    .m1_addr_i(addr[1]),
    .m1_wdata_i(wdata[1]),
    .m1_ack_o(ack1),
    .m1_err_o(err1),
    .m1_rdata_o(rd1),
`ifdef MEM_BUS_ARBITER_LOCK_EN
    .m0_lock_i(lock[0]),
    .m1_lock_i(lock[1]),
`endif
    .addr_o(b_addr),
    .re_o(b_re),
    .we_o(b_we),
    .data_o(b_do),
    .data_oe_o(b_oe),
    .data_i(b_di),
    .needWait_i(b_wait),
    .grant_o(grant)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    last   = 1;
    mrd[0] = 16'h0;
    mrd[1] = 16'h0;
    lk_act = 0;
  endtask

  // Called just after a posedge with the DUT in IDLE
  task automatic round(input int w,
                       input logic [15:0] dv,
                       input bit rnd);
    int          win;
    int          k;
    bit          to;
    logic [15:0] cap;
    if (lk_act && !lock[lk_id]) lk_act = 0;
    win = -1;
    if (lk_act) begin
      if (req[lk_id]) win = lk_id;
    end else begin
      if (req == 2'b11)      win = 1 - last;
      else if (req == 2'b01) win = 0;
      else if (req == 2'b10) win = 1;
      if (win >= 0) last = win;
    end
    @(negedge clk);
    check("idle_grant", {30'd0, grant}, 0);
    check("idle_strb", {27'd0, b_re, b_we, b_oe, ack0, ack1}, 0);
    @(posedge clk);
    #1;
    if (win < 0) return;
    k  = 0;
    to = 0;
    cap = 16'h0;
    while (1) begin
      b_wait = (k < w);
      b_di   = rnd ? 16'($urandom) : dv;
      @(negedge clk);
      check("bus_grant", {30'd0, grant}, (win == 1) ? 2 : 1);
      check("bus_re", {31'd0, b_re}, {31'd0, !wr[win]});
      check("bus_we", {30'd0, b_we, b_oe}, wr[win] ? 3 : 0);
      check("bus_addr", {16'd0, b_addr}, {16'd0, addr[win]});
      if (wr[win]) check("bus_data", {16'd0, b_do}, {16'd0, wdata[win]});
      check("bus_ack", {30'd0, ack1, ack0}, 0);
      @(posedge clk);
      cap = b_di;
      if (!b_wait) break;
      k++;
      if (k == MW) begin
        to = 1;
        break;
      end
      #1;
    end
    #1;
    b_wait = 1'b0;
    if (!to && !wr[win]) mrd[win] = cap;
    @(negedge clk);
    check("done_ack", {30'd0, ack1, ack0}, 1 << win);
    check("done_err", {30'd0, err1, err0}, to ? (1 << win) : 0);
    check("done_strb", {29'd0, b_re, b_we, b_oe}, 0);
    check("done_rd0", {16'd0, rd0}, {16'd0, mrd[0]});
    check("done_rd1", {16'd0, rd1}, {16'd0, mrd[1]});
    if (lock[win]) begin
      lk_act = 1;
      lk_id  = win;
    end
    req[win] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    req[i]   = 1'b1;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
  endtask

  initial begin
    addr[0] = 0; addr[1] = 0;
    wdata[0] = 0; wdata[1] = 0;
    model_reset();
    #2;
    check("rst_strb", {27'd0, b_re, b_we, b_oe, ack0, ack1}, 0);
    check("rst_bus", {b_addr, b_do}, 0);
    check("rst_misc", {26'd0, grant, err0, err1, 2'b00}, 0);
    check("rst_rd", {rd1, rd0}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    set_m(0, 1'b0, 16'h1234, 16'h0);
    round(0, 16'hBEEF, 0);
    check("t1_rdata", {16'd0, rd0}, 32'hBEEF);

    set_m(1, 1'b1, 16'h0040, 16'hA5A5);
    round(3, 16'h0, 1);

    set_m(0, 1'b0, 16'h0777, 16'h0);
    round(9, 16'h0, 1);
    check("to_keep", {16'd0, rd0}, 32'hBEEF);
    set_m(0, 1'b0, 16'h0778, 16'h0);
    round(1, 16'h1111, 0);

    for (int n = 0; n < 6; n++) begin
      if (!req[0]) set_m(0, 1'($urandom), 16'($urandom), 16'($urandom));
      if (!req[1]) set_m(1, 1'($urandom), 16'($urandom), 16'($urandom));
      round(n % 3, 16'h0, 1);
    end
    req = 2'b00;

    set_m(0, 1'b0, 16'h2222, 16'h0);
    @(posedge clk);
    #1;
    b_wait = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_strb", {27'd0, b_re, b_we, b_oe, ack0, ack1}, 0);
    check("mid_bus", {b_addr, b_do}, 0);
    check("mid_grant", {30'd0, grant}, 0);
    check("mid_rd", {rd1, rd0}, 0);
    req = 2'b00;
    b_wait = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_m(0, 1'b1, 16'h0011, 16'h5555);
    set_m(1, 1'b1, 16'h0022, 16'h6666);
    round(0, 16'h0, 1);
    check("tie_m0", {31'd0, req[1]}, 1);
    round(0, 16'h0, 1);

`ifdef MEM_BUS_ARBITER_LOCK_EN
    lock = 2'b10;
    set_m(1, 1'b0, 16'h0100, 16'h0);
    round(0, 16'h0, 1);
    set_m(0, 1'b0, 16'h0200, 16'h0);
    set_m(1, 1'b1, 16'h0100, 16'h00FF);
    round(1, 16'h0, 1);
    check("lock_hold", {30'd0, req}, 2'b01);
    lock = 2'b00;
    round(0, 16'h0, 1);
    check("lock_rel", {30'd0, req}, 2'b00);
`endif

    repeat (300) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(0, 2) != 0)
          set_m(i, 1'($urandom), 16'($urandom), 16'($urandom));
      end
      if ($urandom_range(0, 9) < 7)
        round($urandom_range(0, 2), 16'h0, 1);
      else
        round($urandom_range(3, 6), 16'h0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
